// File: rtl/mul_hilo_controller.sv
// HI/LO controller for a two-stage pipelined 32x32 multiplier.
// Holds the architectural HI/LO and performs the MADD/MSUB accumulate step.
module mul_hilo_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [DATA_WIDTH-1:0]     req_src1,
    input  logic [DATA_WIDTH-1:0]     req_src2,
    input  logic                      flush,
    output logic [DATA_WIDTH-1:0]     mul_input1,
    output logic [DATA_WIDTH-1:0]     mul_input2,
    output logic                      mul_is_signed,
    input  logic [2*DATA_WIDTH-1:0]   mul_result,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo,
    output logic                      busy
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_MADD = 3'd2;
    localparam logic [2:0] OP_MSUB = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic                  accept;
    logic [PW-1:0]         hilo;
    logic [PW-1:0]         acc_res;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign accept     = req_valid & req_ready & ~flush;
    assign mul_input1 = req_src1;
    assign mul_input2 = req_src2;
    assign hi         = hi_q;
    assign lo         = lo_q;

    assign mul_is_signed = (req_op == OP_MULT) |
                           (req_op == OP_MADD) |
                           (req_op == OP_MSUB);

    // op bit 2 separates the MSUB pair from the MADD pair
    assign hilo    = {hi_q, lo_q};
    assign acc_res = op_q[2] ? (hilo - prod_q) : (hilo + prod_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        (req_op == OP_MTHI): hi_d = req_src1;
                        (req_op == OP_MTLO): lo_d = req_src1;
                        default: begin
                            state_d = S_MUL;
                            op_d    = req_op;
                        end
                    endcase
                end
            end
            S_MUL: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (op_q[2:1] == 2'b00) begin
                        {hi_d, lo_d} = mul_result;
                    end else begin
                        prod_d  = mul_result;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                state_d = S_IDLE;
                if (!flush) begin
                    {hi_d, lo_d} = acc_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_hilo_controller.sv
// Bench for mul_hilo_controller: directed HI/LO scenarios plus random
// traffic compared each cycle against a transaction-level HI/LO model.
module tb_mul_hilo_controller;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_op = '0;
    logic [W-1:0]  req_src1 = '0;
    logic [W-1:0]  req_src2 = '0;
    logic          flush = 1'b0;
    logic [63:0]   mul_result = '0;
    logic          req_ready;
    logic [W-1:0]  mul_input1;
    logic [W-1:0]  mul_input2;
    logic          mul_is_signed;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_hilo = '0;
    logic [63:0] m_val = '0;
    logic [63:0] m_p = '0;
    bit          m_pend = 1'b0;
    int          m_cnt = 0;

    mul_hilo_controller #(.DATA_WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_src1(req_src1),
        .req_src2(req_src2),
        .flush(flush),
        .mul_input1(mul_input1),
        .mul_input2(mul_input2),
        .mul_is_signed(mul_is_signed),
        .mul_result(mul_result),
        .hi(hi),
        .lo(lo),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mulx(bit s, logic [31:0] a, logic [31:0] b);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    function automatic bit sgn(logic [2:0] op);
        return (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // External pipelined multiplier: samples its operand bus every edge
    always @(posedge clock)
        mul_result <= mulx(mul_is_signed, mul_input1, mul_input2);

    // Reference: an accepted op commits its final HI:LO after 1 (MULT) or
    // 2 (MADD/MSUB) edges unless a flush cancels it first.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hilo = '0;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_val  = '0;
        end else if (m_pend) begin
            if (flush) begin
                m_pend = 1'b0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hilo = m_val;
                    m_pend = 1'b0;
                end
            end
        end else if (req_valid && !flush) begin
            if (req_op == 3'd6) begin
                m_hilo[63:32] = req_src1;
            end else if (req_op == 3'd7) begin
                m_hilo[31:0] = req_src1;
            end else begin
                m_p = mulx(sgn(req_op), req_src1, req_src2);
                if (req_op < 3'd2)      m_val = m_p;
                else if (req_op < 3'd4) m_val = m_hilo + m_p;
                else                    m_val = m_hilo - m_p;
                m_cnt  = (req_op < 3'd2) ? 1 : 2;
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("hi", {32'b0, hi}, {32'b0, m_hilo[63:32]});
            chk("lo", {32'b0, lo}, {32'b0, m_hilo[31:0]});
            chk("busy", {63'b0, busy}, {63'b0, m_pend});
            chk("req_ready", {63'b0, req_ready}, {63'b0, !m_pend});
            chk("mul_is_signed", {63'b0, mul_is_signed}, {63'b0, sgn(req_op)});
            chk("mul_input1", {32'b0, mul_input1}, {32'b0, req_src1});
            chk("mul_input2", {32'b0, mul_input2}, {32'b0, req_src2});
        end
    end

    task automatic drv(bit v, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit f);
        @(negedge clock);
        #1;
        req_valid = v;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        flush     = f;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic hl(string name, logic [31:0] eh, logic [31:0] el);
        chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({name, "_lo"}, {32'b0, lo}, {32'b0, el});
    endtask

    initial begin
        repeat (2) @(negedge clock);
        hl("reset", 32'h0, 32'h0);
        chk("reset_ready", {63'b0, req_ready}, 64'd1);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // MULT -3 x 5
        drv(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        idle();
        chk("mult_busy_e0", {63'b0, busy}, 64'd1);
        idle();
        chk("mult_busy_e1", {63'b0, busy}, 64'd0);
        hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // MULTU and MULT of all-ones
        drv(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle();
        idle();
        hl("multu_ones", 32'hFFFF_FFFE, 32'h0000_0001);
        drv(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle();
        idle();
        hl("mult_ones", 32'h0, 32'h1);

        // MADDU wraps to zero, then MSUB of -2
        drv(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
        drv(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b0);
        drv(1'b1, 3'd3, 32'h1, 32'h1, 1'b0);
        idle();
        idle();
        hl("maddu_before", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();
        hl("maddu_wrap", 32'h0, 32'h0);
        drv(1'b1, 3'd4, 32'h2, 32'hFFFF_FFFF, 1'b0);
        idle();
        idle();
        idle();
        hl("msub", 32'h0, 32'h2);

        // Flush in the MUL cycle of MADD 7x6
        drv(1'b1, 3'd2, 32'd7, 32'd6, 1'b0);
        drv(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        idle();
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_ready", {63'b0, req_ready}, 64'd1);
        idle();
        hl("flush_mul", 32'h0, 32'h2);

        // Flush wins over a presented request in IDLE
        drv(1'b1, 3'd7, 32'd55, 32'h0, 1'b1);
        idle();
        hl("flush_mtlo", 32'h0, 32'h2);
        drv(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
        idle();
        chk("flush_idle_busy", {63'b0, busy}, 64'd0);

        // Back-to-back MULTs with valid held
        drv(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        drv(1'b1, 3'd0, 32'd4, 32'd5, 1'b0);
        drv(1'b1, 3'd0, 32'd4, 32'd5, 1'b0);
        hl("b2b_first", 32'h0, 32'd6);
        idle();
        idle();
        hl("b2b_second", 32'h0, 32'd20);

        // MTLO every cycle
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 3'd7, 32'd9, 32'h0, 1'b0);
            chk("mtlo_ready", {63'b0, req_ready}, 64'd1);
        end
        idle();
        hl("mtlo_rep", 32'h0, 32'd9);

        // Reset during the ACC cycle of MADD 3x3 onto hi:lo = 1
        drv(1'b1, 3'd6, 32'h0, 32'h0, 1'b0);
        drv(1'b1, 3'd7, 32'h1, 32'h0, 1'b0);
        drv(1'b1, 3'd2, 32'd3, 32'd3, 1'b0);
        idle();
        idle();
        chk("acc_busy", {63'b0, busy}, 64'd1);
        #1 reset = 1'b0;
        #1;
        hl("async_rst", 32'h0, 32'h0);
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_ready", {63'b0, req_ready}, 64'd1);
        #1 reset = 1'b1;
        idle();
        idle();
        hl("rst_no_wb", 32'h0, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                pick(), pick(), $urandom_range(0, 15) == 0);
        end
        idle();
        idle();
        idle();
        @(negedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
